// File: rtl/load_exec_unit.sv
// load_exec_unit: execute-stage load unit.
// Forms ea = rs1_data + sext(imm), performs one data-memory read handshake,
// extracts byte/half/word from the little-endian return word and presents a
// one-cycle writeback pulse. One load in flight at a time.
//
// load_control encoding (matches processor_defines.sv):
//   LB=3'b000  LH=3'b001  LW=3'b010  LBU=3'b100  LHU=3'b101  LD_NOP=3'b111
//   Any other code is treated like LD_NOP (illegal op).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        request handshake (accepted when both high)
//   rs1_data, imm, rd          base, signed 12-bit offset, destination
//   load_control               load type
//   mem_req, mem_addr          read request (held until mem_ack), word address
//   mem_ack, mem_rdata         read data valid strobe and word
//   done, wb_en, wb_rd,        completion pulse, register write enable,
//   wb_data, fault_code        destination, result, fault (0/1/2/3)
module load_exec_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1_data,
    input  logic [11:0] imm,
    input  logic [4:0]  rd,
    input  logic [2:0]  load_control,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  fault_code
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd2;
    localparam logic [1:0] FLT_ILLEGAL  = 2'd3;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         rd_q, rd_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         off_q, off_d;

    logic               in_ready_q, in_ready_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               done_q, done_d;
    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [1:0]         fault_code_q, fault_code_d;

    logic [31:0]        ea_c;
    logic               illegal_c;
    logic               misalign_c;
    logic               timeout_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        ext_c;

    // Accept-time address and fault classification
    always_comb begin
        ea_c       = rs1_data + {{20{imm[11]}}, imm};
        illegal_c  = !(load_control inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
        misalign_c = ((load_control == OP_LH || load_control == OP_LHU) && ea_c[0])
                   || (load_control == OP_LW && ea_c[1:0] != 2'b00);
    end

    // Timeout fires on the TIMEOUT_CYCLES-th request cycle; 0 disables it
    always_comb begin
        timeout_c = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) + 32'd1 == 32'(TIMEOUT_CYCLES));
    end

    // Lane extraction and extension from the returned word
    always_comb begin
        byte_c = mem_rdata[8*off_q +: 8];
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   ext_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  ext_c = {24'd0, byte_c};
            OP_LH:   ext_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  ext_c = {16'd0, half_c};
            default: ext_c = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load-context logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        op_d    = op_q;
        off_d   = off_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d  = rd;
                    op_d  = load_control;
                    off_d = ea_c[1:0];
                    cnt_d = '0;
                    state_d = (illegal_c || misalign_c) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_c) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered output values
    always_comb begin
        in_ready_d   = (state_d == S_IDLE);
        mem_req_d    = (state_d == S_WAIT);
        mem_addr_d   = mem_addr_q;
        done_d       = 1'b0;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (illegal_c || misalign_c) begin
                        done_d       = 1'b1;
                        wb_rd_d      = rd;
                        wb_data_d    = '0;
                        fault_code_d = illegal_c ? FLT_ILLEGAL : FLT_MISALIGN;
                    end else begin
                        mem_addr_d = {ea_c[31:2], 2'b00};
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    done_d       = 1'b1;
                    wb_en_d      = (rd_q != 5'd0);
                    wb_rd_d      = rd_q;
                    wb_data_d    = ext_c;
                    fault_code_d = FLT_NONE;
                end else if (timeout_c) begin
                    done_d       = 1'b1;
                    wb_rd_d      = rd_q;
                    wb_data_d    = '0;
                    fault_code_d = FLT_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            rd_q         <= '0;
            op_q         <= '0;
            off_q        <= '0;
            in_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            done_q       <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            fault_code_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            op_q         <= op_d;
            off_q        <= off_d;
            in_ready_q   <= in_ready_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            done_q       <= done_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign done       = done_q;
    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_load_exec_unit.sv
// Testbench for load_exec_unit: directed scenarios plus randomized loads
// checked against an arithmetic reference model.
module tb_load_exec_unit;

    localparam int unsigned TMO = 16;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  load_control;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;

    load_exec_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .imm(imm), .rd(rd), .load_control(load_control),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: value loaded from word w at byte address ea
    function automatic logic [31:0] model_value(input logic [2:0] op, input logic [31:0] ea,
                                                input logic [31:0] w);
        logic [31:0] bytev;
        logic [31:0] halfv;
        bytev = (w >> (8 * ea[1:0])) & 32'hFF;
        halfv = (w >> (16 * ea[1])) & 32'hFFFF;
        case (op)
            LB:      return (bytev >= 32'd128) ? bytev - 32'd256 : bytev;
            LBU:     return bytev;
            LH:      return (halfv >= 32'd32768) ? halfv - 32'd65536 : halfv;
            LHU:     return halfv;
            default: return w;
        endcase
    endfunction

    function automatic logic [1:0] model_fault(input logic [2:0] op, input logic [31:0] ea);
        if (!(op == LB || op == LH || op == LW || op == LBU || op == LHU)) return 2'd3;
        if ((op == LH || op == LHU) && (ea % 2 != 0)) return 2'd1;
        if (op == LW && (ea % 4 != 0)) return 2'd1;
        return 2'd0;
    endfunction

    // Issue one load, respond to the request with ack on request cycle ack_at
    // (0 = never), and check the complete transaction against the model.
    task automatic run_load(input logic [31:0] rs1, input logic [11:0] im, input logic [4:0] rdv,
                            input logic [2:0] op, input int ack_at, input logic [31:0] rdata,
                            input string name);
        logic [31:0] ea;
        logic [1:0]  exp_fault;
        int          exp_req;
        int          exp_done;
        logic [31:0] exp_data;
        logic        exp_wben;
        int          cyc;
        int          req_cnt;
        int          done_cyc;
        logic [31:0] got_data;
        logic [1:0]  got_fault;
        logic        got_wben;
        logic        got_req;
        logic [4:0]  got_rd;

        ea = rs1 + 32'($signed(im));
        exp_fault = model_fault(op, ea);
        if (exp_fault != 2'd0) begin
            exp_req = 0;
            exp_done = 1;
        end else if (ack_at >= 1 && ack_at <= int'(TMO)) begin
            exp_req = ack_at;
            exp_done = ack_at + 1;
        end else begin
            exp_req = int'(TMO);
            exp_done = int'(TMO) + 1;
            exp_fault = 2'd2;
        end
        exp_data = (exp_fault == 2'd0) ? model_value(op, ea, rdata) : 32'd0;
        exp_wben = (exp_fault == 2'd0) && (rdv != 5'd0);

        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, in_ready);
        end

        in_valid = 1'b1;
        rs1_data = rs1;
        imm = im;
        rd = rdv;
        load_control = op;
        step();
        in_valid = 1'b0;
        rs1_data = $urandom;
        imm = 12'($urandom);
        rd = 5'($urandom);
        load_control = 3'($urandom);

        cyc = 1;
        req_cnt = 0;
        done_cyc = -1;
        got_data = '0;
        got_fault = '0;
        got_wben = 1'b0;
        got_req = 1'b0;
        got_rd = '0;
        while (cyc < 60) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                got_data = wb_data;
                got_fault = fault_code;
                got_wben = wb_en;
                got_req = mem_req;
                got_rd = wb_rd;
                break;
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready cyc %0d: got %b expected 0", name, cyc, in_ready);
            end
            if (mem_req === 1'b1) begin
                req_cnt++;
                checks++;
                if (mem_addr !== {ea[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL %s mem_addr cyc %0d: got %h expected %h", name, cyc, mem_addr,
                             {ea[31:2], 2'b00});
                end
                mem_ack = (req_cnt == ack_at);
                mem_rdata = mem_ack ? rdata : $urandom;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            step();
            mem_ack = 1'b0;
            cyc++;
        end

        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (req_cnt != exp_req) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d expected %0d", name, req_cnt, exp_req);
        end
        checks++;
        if (got_fault !== exp_fault) begin
            errors++;
            $display("FAIL %s fault_code: got %0d expected %0d", name, got_fault, exp_fault);
        end
        checks++;
        if (got_data !== exp_data) begin
            errors++;
            $display("FAIL %s wb_data: got %h expected %h", name, got_data, exp_data);
        end
        checks++;
        if (got_wben !== exp_wben) begin
            errors++;
            $display("FAIL %s wb_en: got %b expected %b", name, got_wben, exp_wben);
        end
        checks++;
        if (got_rd !== rdv) begin
            errors++;
            $display("FAIL %s wb_rd: got %0d expected %0d", name, got_rd, rdv);
        end
        checks++;
        if (got_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_at_done: got %b expected 0", name, got_req);
        end

        // One cycle later: pulse over, unit idle, results held
        step();
        checks++;
        if (done !== 1'b0 || wb_en !== 1'b0 || in_ready !== 1'b1 || wb_data !== exp_data
            || fault_code !== exp_fault) begin
            errors++;
            $display("FAIL %s after_done: got done=%b wb_en=%b ready=%b data=%h fault=%0d expected 0 0 1 %h %0d",
                     name, done, wb_en, in_ready, wb_data, fault_code, exp_data, exp_fault);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0 ||
            mem_addr !== 32'd0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || fault_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b req=%b done=%b wb_en=%b addr=%h rd=%0d data=%h fault=%0d expected 1 0 0 0 0 0 0 0",
                     in_ready, mem_req, done, wb_en, mem_addr, wb_rd, wb_data, fault_code);
        end
    endtask

    task automatic test_directed();
        run_load(32'h1000, 12'h004, 5'd1, LW, 1, 32'hDEADBEEF, "lw_zero_wait");
        run_load(32'h1003, 12'h000, 5'd2, LB, 2, 32'h80112233, "lb_sext");
        run_load(32'h1003, 12'h000, 5'd3, LBU, 3, 32'h80112233, "lbu_zext");
        run_load(32'h1002, 12'hFFF, 5'd4, LH, 1, 32'h12345678, "lh_misaligned");
        run_load(32'h1000, 12'h000, 5'd5, LW, 0, 32'h0, "lw_timeout");
        run_load(32'h1000, 12'h000, 5'd6, LW, 16, 32'hCAFEF00D, "lw_ack_on_last");
        run_load(32'h1000, 12'h000, 5'd7, NOP, 1, 32'h0, "ld_nop");
        run_load(32'h1000, 12'h000, 5'd0, LW, 2, 32'h55AA55AA, "lw_rd0");
        run_load(32'h2002, 12'h000, 5'd8, LHU, 1, 32'hABCD0000, "lhu_upper");
        run_load(32'h2000, 12'h002, 5'd9, LH, 4, 32'h8001FFFF, "lh_sext_upper");
        run_load(32'h1001, 12'h001, 5'd10, LW, 1, 32'h0, "lw_misaligned");
        run_load(32'hFFFFFFFC, 12'h008, 5'd11, LW, 1, 32'h01020304, "lw_ea_wrap");
        run_load(32'h0000_0010, 12'h003, 5'd12, 3'b011, 1, 32'h0, "illegal_011");
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1;
        rs1_data = 32'h3000;
        imm = 12'h0;
        rd = 5'd13;
        load_control = LW;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_req_pre: got %b expected 1", mem_req);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_after: got req=%b ready=%b done=%b expected 0 1 0",
                     mem_req, in_ready, done);
        end
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (done !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait_quiet cyc %0d: got done=%b req=%b expected 0 0", i, done, mem_req);
            end
        end
        mem_ack = 1'b0;
        run_load(32'h3000, 12'h010, 5'd14, LW, 2, 32'h13579BDF, "lw_after_reset");
    endtask

    task automatic test_random();
        logic [2:0] ops [8];
        logic [31:0] rs1;
        ops = '{LB, LH, LW, LBU, LHU, NOP, 3'b011, 3'b110};
        for (int n = 0; n < 150; n++) begin
            rs1 = $urandom;
            if ($urandom_range(0, 1) == 1) rs1[1:0] = 2'b00;
            run_load(rs1, 12'($urandom), 5'($urandom), ops[$urandom_range(0, 7)],
                     int'($urandom_range(1, 20)), $urandom, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        rs1_data = '0;
        imm = '0;
        rd = '0;
        load_control = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
